// File: rtl/bin_to_bcd_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_pkg
//  Brief    : Shared types and constants for the sequential double-dabble
//             binary-to-BCD converter.
//  Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  // Converter control states
  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

  localparam int BCD_DIGIT_W = 4;

  // Double-dabble correction: a digit >= 5 would become >= 10 after the
  // shift, so it is pre-biased by 3 to carry correctly into the next digit.
  localparam logic [BCD_DIGIT_W-1:0] ADJUST_THRESH = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] ADJUST_ADD    = 4'd3;

  // Width of a counter that must reach width-1; never narrower than 1 bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bin_to_bcd_seq_digit_adjust.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_digit_adjust
//  Brief    : Combinational "add 3 if >= 5" correction for one BCD digit.
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  // Input digits are always 0..9, so the corrected value fits in 4 bits.
  assign digit_o = (digit_i >= ADJUST_THRESH) ? (digit_i + ADJUST_ADD) : digit_i;

endmodule : bcd_digit_adjust
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bin_to_bcd_seq
//  Brief    : Sequential double-dabble binary-to-BCD converter, one shift per
//             clock, WIDTH cycles per conversion.
//  Options  : BCD_SIGNED_EN - treat value as two's complement; convert the
//             magnitude and report the sign on negative.
//  Revision : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [WIDTH-1:0]              value,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          negative
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // DIGITS must be able to represent the largest input.
  if (10 ** DIGITS <= (2 ** WIDTH) - 1) begin : g_digits_check
    $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
  end

  state_t               state_q;
  logic [WIDTH-1:0]     shift_q;
  logic [BCD_W-1:0]     scratch_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic [BCD_W-1:0]     bcd_q;

  logic [WIDTH-1:0]     w_mag;
  logic [BCD_W-1:0]     w_adjusted;
  logic [BCD_W+WIDTH-1:0] w_shifted;
  logic [BCD_W-1:0]     scratch_d;
  logic [WIDTH-1:0]     shift_d;

`ifdef BCD_SIGNED_EN
  logic                 sign_q;
  logic                 neg_q;

  // Magnitude of a two's complement operand; the most negative code maps to
  // its unsigned magnitude (e.g. 0x80 -> 128) because the result is WIDTH bits.
  assign w_mag    = value[WIDTH-1] ? (~value + WIDTH'(1)) : value;
  assign negative = neg_q;
`else
  assign w_mag    = value;
  assign negative = 1'b0;
`endif

  // Per-digit correction ahead of each shift
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adjust
    bcd_digit_adjust u_adj (
      .digit_i (scratch_q [gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (w_adjusted[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // One double-dabble step: shift {corrected scratch, operand} left by one
  assign w_shifted = {w_adjusted, shift_q} << 1;
  assign scratch_d = w_shifted[BCD_W+WIDTH-1:WIDTH];
  assign shift_d   = w_shifted[WIDTH-1:0];

  // Control FSM with registered outputs; result only updates at completion
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
`ifdef BCD_SIGNED_EN
      sign_q    <= 1'b0;
      neg_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            shift_q   <= w_mag;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= CONVERT;
`ifdef BCD_SIGNED_EN
            sign_q    <= value[WIDTH-1];
`endif
          end
        end
        CONVERT: begin
          shift_q   <= shift_d;
          scratch_q <= scratch_d;
          cnt_q     <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            bcd_q   <= scratch_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
`ifdef BCD_SIGNED_EN
            neg_q   <= sign_q;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;

endmodule : bin_to_bcd_seq
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bin_to_bcd_seq
//  Brief    : Self-checking bench for bin_to_bcd_seq (default parameters).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_seq;

  localparam int WIDTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  value = 8'h00;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;
  logic        negative;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int cyc      = 0;

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .value    (value),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .negative (negative)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  typedef struct {
    logic [7:0]  v;
    logic [11:0] bcd_u;   // unsigned-build result
    logic [11:0] bcd_s;   // signed-build result
    logic        neg_s;   // signed-build sign
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: decimal digits via division, independent of double dabble
  function automatic logic [11:0] ref_bcd(input logic [7:0] v);
    int n;
`ifdef BCD_SIGNED_EN
    n = v[7] ? (256 - int'(v)) : int'(v);
`else
    n = int'(v);
`endif
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic logic ref_neg(input logic [7:0] v);
`ifdef BCD_SIGNED_EN
    return v[7];
`else
    return 1'b0 & v[0];
`endif
  endfunction

  // One full conversion with latency, busy and single-pulse checks
  task automatic run_conv(input logic [7:0] v, input logic [11:0] eb, input logic en, input string nm);
    int lat;
    logic busy_ok;
    @(negedge clk);
    start = 1'b1;
    value = v;
    @(posedge clk); #1;
    start = 1'b0;
    busy_ok = busy & ~done;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (done !== 1'b1 && busy !== 1'b1) busy_ok = 1'b0;
    end
    chk({nm, " latency"}, lat, WIDTH);
    chk({nm, " busy_held"}, busy_ok, 1);
    chk({nm, " busy_at_done"}, busy, 0);
    chk({nm, " bcd"}, bcd_out, eb);
    chk({nm, " neg"}, negative, en);
    @(posedge clk); #1;
    chk({nm, " done_pulse"}, done, 0);
    chk({nm, " bcd_hold"}, bcd_out, eb);
  endtask

  initial begin
    int d0, c1, c2, guard;

    vecs[0] = '{8'h00, 12'h000, 12'h000, 1'b0};
    vecs[1] = '{8'hFF, 12'h255, 12'h001, 1'b1};
    vecs[2] = '{8'h80, 12'h128, 12'h128, 1'b1};
    vecs[3] = '{8'h7F, 12'h127, 12'h127, 1'b0};
    vecs[4] = '{8'd100, 12'h100, 12'h100, 1'b0};
    vecs[5] = '{8'd7,   12'h007, 12'h007, 1'b0};
    vecs[6] = '{8'd42,  12'h042, 12'h042, 1'b0};
    vecs[7] = '{8'd200, 12'h200, 12'h056, 1'b1};
    vecs[8] = '{8'd153, 12'h153, 12'h103, 1'b1};
    vecs[9] = '{8'd99,  12'h099, 12'h099, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset bcd", bcd_out, 0);
    chk("reset neg", negative, 0);
    @(negedge clk);
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 10; i++) begin
`ifdef BCD_SIGNED_EN
      run_conv(vecs[i].v, vecs[i].bcd_s, vecs[i].neg_s, $sformatf("vec%0d", i));
`else
      run_conv(vecs[i].v, vecs[i].bcd_u, 1'b0, $sformatf("vec%0d", i));
`endif
    end

    // Every input against the division model
    for (int v = 0; v < 256; v++) begin
      run_conv(8'(v), ref_bcd(8'(v)), ref_neg(8'(v)), $sformatf("all%0d", v));
    end

    // start while busy is ignored
    d0 = done_cnt;
    @(negedge clk); start = 1'b1; value = 8'd100;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; value = 8'd7;
    @(negedge clk); start = 1'b0;
    repeat (12) @(negedge clk);
    chk("ignore bcd", bcd_out, 12'h100);
    chk("ignore done_count", done_cnt - d0, 1);
    chk("ignore busy", busy, 0);

    // Reset mid-conversion aborts with no done pulse
    d0 = done_cnt;
    @(negedge clk); start = 1'b1; value = 8'd42;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("abort busy", busy, 0);
    chk("abort bcd", bcd_out, 0);
    chk("abort done", done, 0);
    @(negedge clk); reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("abort no_done", done_cnt - d0, 0);
    chk("abort idle_busy", busy, 0);
    run_conv(8'd42, ref_bcd(8'd42), 1'b0, "restart");

    // Back-to-back: start held high, next value accepted in the done cycle
    @(negedge clk); start = 1'b1; value = 8'd9;
    guard = 0;
    do begin @(posedge clk); #1; guard++; end while (done !== 1'b1 && guard < 30);
    c1 = cyc;
    chk("b2b first bcd", bcd_out, ref_bcd(8'd9));
    value = 8'd250;
    guard = 0;
    do begin @(posedge clk); #1; guard++; end while (done !== 1'b1 && guard < 30);
    c2 = cyc;
    start = 1'b0;
    chk("b2b second bcd", bcd_out, ref_bcd(8'd250));
    chk("b2b second neg", negative, ref_neg(8'd250));
    chk("b2b spacing", c2 - c1, WIDTH + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_bin_to_bcd_seq
`default_nettype wire
